// File: rtl/da_pkg.sv
// Shared types and helpers for the DA coefficient-ROM sequencer.
// The ROM stores only the x0-bit-clear half, so the other half comes from complementing the address and negating the data.
package da_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        BIAS = 2'd2,
        HOLD = 2'd3
    } state_e;

    typedef enum logic [2:0] {
        ACC_HOLD      = 3'd0,
        ACC_CLEAR     = 3'd1,
        ACC_FIRST     = 3'd2,
        ACC_SHIFT_ADD = 3'd3,
        ACC_BIAS      = 3'd4
    } acc_op_e;

    localparam int ROM_AW = 3;
    localparam logic [ROM_AW-1:0] BIAS_ADDR = 3'b000;

    typedef struct packed {
        logic              negate;
        logic [ROM_AW-1:0] addr;
    } addr_sel_t;

    // The x0=1 half of the table is the negated mirror of the x0=0 half.
    function automatic addr_sel_t da_addr_sel(input logic b0, input logic b1,
                                              input logic b2, input logic b3);
        addr_sel_t sel;
        sel.negate = b0;
        sel.addr   = b0 ? ~{b1, b2, b3} : {b1, b2, b3};
        return sel;
    endfunction

endpackage

// File: rtl/da_accum.sv
// Shift-add accumulator for one DA output coefficient.
// Takes a ROM word, optionally negates it at full width, and folds it into the running sum.
module da_accum
    import da_pkg::*;
#(
    parameter int RW = 16,
    parameter int AW = 34
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  acc_op_e              op,
    input  logic                 negate,
    input  logic signed [RW-1:0] rom_data,
    output logic signed [AW-1:0] acc
);

    logic signed [AW-1:0] t_ext;
    logic signed [AW-1:0] term;

    // Negating after sign extension keeps -(-2^(RW-1)) representable.
    always_comb begin
        t_ext = {{(AW-RW){rom_data[RW-1]}}, rom_data};
        term  = negate ? -t_ext : t_ext;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else begin
            case (op)
                ACC_CLEAR:     acc <= '0;
                ACC_FIRST:     acc <= -term;
                ACC_SHIFT_ADD: acc <= (acc <<< 1) + term;
                ACC_BIAS:      acc <= acc + t_ext;
                default:       acc <= acc;
            endcase
        end
    end

endmodule

// File: rtl/da_dct_row_seq.sv
// Bit-serial DA sequencer: walks the sample bit-planes MSB-first against a half-size
// offset-binary coefficient ROM and produces one exact DCT coefficient per vector.
module da_dct_row_seq
    import da_pkg::*;
#(
    parameter int DW = 16,
    parameter int RW = 16,
    parameter int AW = 34
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DW-1:0]     x0,
    input  logic signed [DW-1:0]     x1,
    input  logic signed [DW-1:0]     x2,
    input  logic signed [DW-1:0]     x3,
    output logic [ROM_AW-1:0]        rom_addr,
    output logic                     rom_cs,
    input  logic signed [RW-1:0]     rom_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [AW-1:0]     z
);

    localparam int CW = $clog2(DW);
    localparam logic [CW-1:0] J_TOP = CW'(DW - 1);

    state_e              state, state_next;
    logic                armed;
    logic [3:0][DW-1:0]  sr;
    logic [CW-1:0]       j;
    addr_sel_t           sel;
    acc_op_e             op;
    logic                negate;
    logic                accept;

    assign sel    = da_addr_sel(sr[0][DW-1], sr[1][DW-1], sr[2][DW-1], sr[3][DW-1]);
    assign accept = (state == IDLE) && armed && in_valid;

    // NOTE: every output is given a default first so no path through the case
    // leaves a value unassigned and infers a latch.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        rom_cs     = 1'b0;
        rom_addr   = '0;
        out_valid  = 1'b0;
        op         = ACC_HOLD;
        negate     = 1'b0;
        case (state)
            IDLE: begin
                in_ready = armed;
                if (accept) begin
                    state_next = RUN;
                    op         = ACC_CLEAR;
                end
            end
            RUN: begin
                rom_cs   = 1'b1;
                rom_addr = sel.addr;
                negate   = sel.negate;
                // The MSB plane carries negative weight in two's complement.
                op       = (j == J_TOP) ? ACC_FIRST : ACC_SHIFT_ADD;
                if (j == '0) state_next = BIAS;
            end
            BIAS: begin
                rom_cs     = 1'b1;
                rom_addr   = BIAS_ADDR;
                op         = ACC_BIAS;
                state_next = HOLD;
            end
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // armed keeps in_ready low until the first edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            armed <= 1'b0;
        end else begin
            state <= state_next;
            armed <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr <= '0;
            j  <= '0;
        end else if (accept) begin
            sr <= {x3, x2, x1, x0};
            j  <= J_TOP;
        end else if (state == RUN) begin
            for (int k = 0; k < 4; k++) begin
                sr[k] <= {sr[k][DW-2:0], 1'b0};
            end
            j <= j - 1'b1;
        end
    end

    da_accum #(
        .RW (RW),
        .AW (AW)
    ) u_accum (
        .clk      (clk),
        .rst_n    (rst_n),
        .op       (op),
        .negate   (negate),
        .rom_data (rom_data),
        .acc      (z)
    );

endmodule

// File: tb/tb_da_dct_row_seq.sv
// Scoreboard bench for da_dct_row_seq with a behavioural offset-binary ROM built from four coefficients.
// Stimulus pushes expected z; an independent monitor pops on each output handshake.
module tb_da_dct_row_seq;

    localparam int DW     = 16;
    localparam int RW     = 16;
    localparam int AW     = 34;
    localparam int LAT    = 17;
    localparam int PERIOD = 19;

    // Q2.14 cos(pi/16), cos(3pi/16), cos(5pi/16), cos(7pi/16); the sum is even so every entry is exact.
    localparam longint C0 = 16069;
    localparam longint C1 = 13623;
    localparam longint C2 = 9102;
    localparam longint C3 = 3196;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic signed [DW-1:0] x0 = '0, x1 = '0, x2 = '0, x3 = '0;
    logic [2:0]           rom_addr;
    logic                 rom_cs;
    logic signed [RW-1:0] rom_data;
    logic                 out_valid;
    logic                 out_ready = 1'b1;
    logic signed [AW-1:0] z;

    logic signed [RW-1:0] rom_img [8];

    typedef struct {
        longint z;
        longint acc_cycle;
    } exp_t;

    exp_t   exp_q[$];
    exp_t   mon_e;
    int     checks = 0;
    int     errors = 0;
    longint cycle = 0;
    logic   prev_valid = 1'b0;

    da_dct_row_seq #(.DW(DW), .RW(RW), .AW(AW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x0        (x0),
        .x1        (x1),
        .x2        (x2),
        .x3        (x3),
        .rom_addr  (rom_addr),
        .rom_cs    (rom_cs),
        .rom_data  (rom_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .z         (z)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    // A deselected ROM returns junk so a missing chip select corrupts z.
    assign rom_data = rom_cs ? rom_img[rom_addr] : 16'sh5A5A;

    function automatic longint golden(input longint a, input longint b,
                                      input longint c, input longint d);
        return C0 * a + C1 * b + C2 * c + C3 * d;
    endfunction

    function automatic logic signed [RW-1:0] rom_entry(input logic [2:0] addr);
        longint s;
        s = -C0 + (addr[2] ? C1 : -C1) + (addr[1] ? C2 : -C2) + (addr[0] ? C3 : -C3);
        return RW'(s / 2);
    endfunction

    task automatic load_production_rom();
        for (int i = 0; i < 8; i++) rom_img[i] = rom_entry(3'(i));
    endtask

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Presents a vector, waits (bounded) for acceptance, optionally records the expected result.
    task automatic send(input logic signed [DW-1:0] a, input logic signed [DW-1:0] b,
                        input logic signed [DW-1:0] c, input logic signed [DW-1:0] d,
                        input bit push, input longint expz, input bit keep_valid,
                        output longint acc_cycle);
        int n;
        n = 0;
        x0 = a; x1 = b; x2 = c; x3 = d;
        in_valid = 1'b1;
        acc_cycle = -1;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) begin
            check("accept_timeout", longint'(in_ready), 1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        acc_cycle = cycle;
        if (!keep_valid) in_valid = 1'b0;
        if (push) exp_q.push_back('{z: expz, acc_cycle: cycle});
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid();
        int n;
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 40) begin
            n++;
            @(negedge clk);
        end
        if (!out_valid) check("valid_timeout", longint'(out_valid), 1);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_in_ready"},  longint'(in_ready),  0);
        check({tag, "_rom_cs"},    longint'(rom_cs),    0);
        check({tag, "_rom_addr"},  longint'(rom_addr),  0);
        check({tag, "_out_valid"}, longint'(out_valid), 0);
        check({tag, "_z"},         longint'(z),         0);
    endtask

    // Monitor: latency on each rising out_valid, value on each output handshake.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && !prev_valid) begin
                if (exp_q.size() == 0) check("unexpected_valid", exp_q.size(), 1);
                else check("latency", cycle - exp_q[0].acc_cycle, LAT);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_result", exp_q.size(), 1);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("z", longint'(z), mon_e.z);
                end
            end
        end
        prev_valid <= out_valid;
    end

    initial begin
        longint t, last;
        logic signed [DW-1:0] a, b, c, d;

        load_production_rom();

        // Reset state, then in_ready one edge after release.
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("release_in_ready",  longint'(in_ready),  1);
        check("release_out_valid", longint'(out_valid), 0);

        // Zero vector cancels exactly for an arbitrary table, including -2^15 entries.
        for (int i = 0; i < 8; i++) rom_img[i] = RW'($urandom);
        rom_img[0] = 16'sh8000;
        rom_img[7] = 16'sh8000;
        send(0, 0, 0, 0, 1, 0, 0, t);
        drain();
        load_production_rom();

        // Hand-computed single-tap and mixed vectors.
        send(1, 0, 0, 0, 1, 16069, 0, t);
        send(0, 1, 0, 0, 1, 13623, 0, t);
        send(0, 0, 1, 0, 1, 9102, 0, t);
        send(0, 0, 0, 1, 1, 3196, 0, t);
        send(1, 1, 1, 1, 1, 41990, 0, t);
        send(100, -200, 300, -400, 1, 334500, 0, t);
        drain();

        // Every RUN plane of (-1,0,0,-1) is x0=1,{0,0,1} -> complemented address 110.
        send(-1, 0, 0, -1, 1, -19265, 0, t);
        for (int k = 0; k < DW; k++) begin
            @(negedge clk);
            check("run_rom_cs",   longint'(rom_cs),   1);
            check("run_rom_addr", longint'(rom_addr), 6);
        end
        @(negedge clk);
        check("bias_rom_cs",   longint'(rom_cs),   1);
        check("bias_rom_addr", longint'(rom_addr), 0);
        @(negedge clk);
        check("hold_rom_cs", longint'(rom_cs), 0);
        drain();

        // Extremes.
        send(-32768, 32767, -32768, 32767, 1, golden(-32768, 32767, -32768, 32767), 0, t);
        send(32767, 32767, 32767, 32767, 1, golden(32767, 32767, 32767, 32767), 0, t);
        send(-32768, -32768, -32768, -32768, 1, golden(-32768, -32768, -32768, -32768), 0, t);
        drain();

        // Stall in HOLD with in_valid pulses during RUN.
        out_ready = 1'b0;
        send(-1234, 5678, -91, 32000, 1, golden(-1234, 5678, -91, 32000), 0, t);
        x0 = 16'sd7; x1 = -16'sd7; x2 = 16'sd99; x3 = 16'sd1;
        in_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_valid();
        for (int k = 0; k < 10; k++) begin
            check("stall_out_valid", longint'(out_valid), 1);
            check("stall_in_ready",  longint'(in_ready),  0);
            check("stall_z",         longint'(z),         golden(-1234, 5678, -91, 32000));
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("post_hs_out_valid", longint'(out_valid), 0);
        check("post_hs_in_ready",  longint'(in_ready),  1);
        drain();

        // Asynchronous reset at bit-plane j=7 discards the vector.
        send(12345, -23456, 4321, -321, 0, 0, 0, t);
        repeat (8) @(posedge clk);
        #2;
        check("midrun_rom_cs", longint'(rom_cs), 1);
        rst_n = 1'b0;
        #1;
        check_idle_outputs("midrun_reset");
        @(posedge clk);
        #1;
        check("in_reset_in_ready", longint'(in_ready), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rerelease_in_ready",  longint'(in_ready),  1);
        check("rerelease_out_valid", longint'(out_valid), 0);
        send(-500, 600, -700, 800, 1, golden(-500, 600, -700, 800), 0, t);
        drain();

        // Back-to-back random vectors at full throughput.
        last = 0;
        for (int i = 0; i < 1000; i++) begin
            a = DW'($urandom); b = DW'($urandom); c = DW'($urandom); d = DW'($urandom);
            send(a, b, c, d, 1, golden(a, b, c, d), 1, t);
            if (i > 0) check("b2b_period", t - last, PERIOD);
            last = t;
        end
        in_valid = 1'b0;
        drain();
        check("final_queue_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
